reg_write_sched: RTL
====================

REG_WRITE_SCHED -- requirements
Module: reg_write_sched

Interface
REQ-001 Parameter: DATA_W, default 32, width of write-back data.
REQ-002 Ports shall be as follows; clock and reset come first:
clk  in  1  single clock; all state changes on rising edge.
reset  in  1  asynchronous, active-high reset.
alu_req  in  1  ALU result ready; destination is rd.
alu_idx  in  5  rd index, for register-0 suppression only.
alu_data  in  DATA_W  ALU result.
alu_ack  out  1  ALU request accepted this cycle.
ld_req  in  1  load result ready; destination is rt.
ld_idx  in  5  rt index.
ld_data  in  DATA_W  load data.
ld_ack  out  1  load request accepted this cycle.
lnk_req  in  1  link write ready; destination is ra (31).
lnk_data  in  DATA_W  return address.
lnk_ack  out  1  link request accepted this cycle.
wr_sel  out  2  write-register mux selector.
wr_data  out  DATA_W  data to register-bank write port.
reg_write  out  1  register-bank write enable.
busy  out  1  state is not IDLE, or any slot is pending.

Function
REQ-003 Selector encoding shall be fixed: rt=2'b10, rd=2'b11, ra=2'b01, alternate=2'b00 (never driven here).
REQ-004 Each requester shall own a 1-deep pending slot holding data and index; source 0=ALU, 1=LD, 2=LNK.
REQ-005 x_ack shall be combinational: x_req & (slot empty | slot cleared this cycle); on ack, the slot loads at that edge.
REQ-006 A slot cleared and reloaded in the same cycle shall hold the new request, with no lost or duplicated write.
REQ-007 The FSM shall have three states: IDLE, SELECT and WRITE.
REQ-008 IDLE -> SELECT at the edge where any slot is pending; the granted source is latched at that edge.
REQ-009 SELECT shall last exactly 1 cycle: wr_sel and wr_data are driven for the grant, and reg_write=0 (mux settle).
REQ-010 WRITE shall last exactly 1 cycle: wr_sel and wr_data are held, reg_write=1, and the granted slot clears at the end of the cycle.
REQ-011 WRITE -> SELECT if another slot is pending, else IDLE; sustained throughput is 1 write per 2 cycles.
REQ-012 Arbitration shall be round-robin: search starts at last_grant+1 mod 3.
REQ-013 A slot-empty-to-reg_write latency of 2 cycles after acceptance, when IDLE, shall be met.
REQ-014 Register 0 rule: a granted ALU or LD request whose idx==0 shall still pass through SELECT/WRITE with reg_write=0, and its slot shall clear.
REQ-015 A LNK request shall never be suppressed.
REQ-016 In IDLE, outputs shall be wr_sel=2'b00, wr_data=0, reg_write=0.
REQ-017 An x_req deasserted while its slot is pending shall not cancel the pending write.

Reset
REQ-018 Reset shall take effect asynchronously: state=IDLE, all slots empty, last_grant=2 (so ALU has first priority), reg_write=0, wr_sel=0, wr_data=0, busy=0, and all acks follow their reqs.
REQ-019 Reset asserted during SELECT or WRITE shall abort the write, with no reg_write pulse after reset assertion, and all pending requests are discarded.

Structure
REQ-020 A shared package reg_write_pkg shall hold: selector constants, state enum, source index constants (SRC_ALU/SRC_LD/SRC_LNK), and RA_IDX=31.
REQ-021 Round-robin selection shall be a sub-module rr_arbiter3 (3 requests, last-grant input, one-hot grant output), combinational.
REQ-022 No other sub-modules shall be used.

Verification
REQ-023 Single ALU write: alu_req=1, alu_idx=8, alu_data=32'hDEAD_BEEF -> alu_ack same cycle; wr_sel=2'b11 for 2 cycles; reg_write=1 exactly on the 2nd cycle.
REQ-024 All three requesters in the same cycle after reset -> grants in order ALU, LD, LNK; wr_sel sequence 11,10,01; 3 reg_write pulses, 2 cycles apart.
REQ-025 Register 0: ld_req with ld_idx=0, ld_data=32'h1234 -> ld_ack=1, wr_sel=2'b10 for 2 cycles, reg_write stays 0, busy drops afterwards.
REQ-026 Back-to-back: alu_req held 6 cycles with a new data value each time accepted -> ack only when the slot is empty or clearing; every accepted value is written exactly once and in order.
REQ-027 Reset in WRITE: assert reset while reg_write=1 -> reg_write=0 within the same cycle (asynchronous); after release, no stale write and busy=0.

Source files
------------

// File: rtl/reg_write_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_pkg
// Purpose  : Shared definitions for the register write-back scheduler:
//            write-register selector codes, requester (source) indices,
//            scheduler state encoding and small conversion helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package reg_write_pkg;

    // Write-register mux selector codes
    localparam logic [1:0] SEL_ALT = 2'b00;  // alternate path, never driven here
    localparam logic [1:0] SEL_RA  = 2'b01;
    localparam logic [1:0] SEL_RT  = 2'b10;
    localparam logic [1:0] SEL_RD  = 2'b11;

    // Requester indices, also the bit positions in request/grant vectors
    localparam int         N_SRC   = 3;
    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_LD  = 2'd1;
    localparam logic [1:0] SRC_LNK = 2'd2;

    // Link writes always target the return-address register
    localparam logic [4:0] RA_IDX  = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SELECT = 2'b01,
        ST_WRITE  = 2'b10
    } state_t;

    function automatic logic [1:0] src_to_sel(input logic [1:0] src);
        logic [1:0] sel;
        case (src)
            SRC_ALU: sel = SEL_RD;
            SRC_LD:  sel = SEL_RT;
            SRC_LNK: sel = SEL_RA;
            default: sel = SEL_ALT;
        endcase
        return sel;
    endfunction

    function automatic logic [1:0] onehot_to_src(input logic [2:0] oh);
        logic [1:0] src;
        case (oh)
            3'b010:  src = SRC_LD;
            3'b100:  src = SRC_LNK;
            default: src = SRC_ALU;
        endcase
        return src;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter3.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter3
// Purpose  : Combinational 3-way round-robin arbiter. The search for a
//            requester starts just after the previously granted source.
// Ports    : req_i  [2:0] request vector (bit n = source n)
//            last_i [1:0] index of the previously granted source
//            gnt_o  [2:0] one-hot grant (all zero when no request)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter3
    import reg_write_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] last_i,
    output logic [2:0] gnt_o
);

    always_comb begin
        gnt_o = 3'b000;
        case (last_i)
            SRC_ALU: begin          // order LD, LNK, ALU
                if      (req_i[1]) gnt_o = 3'b010;
                else if (req_i[2]) gnt_o = 3'b100;
                else if (req_i[0]) gnt_o = 3'b001;
            end
            SRC_LD: begin           // order LNK, ALU, LD
                if      (req_i[2]) gnt_o = 3'b100;
                else if (req_i[0]) gnt_o = 3'b001;
                else if (req_i[1]) gnt_o = 3'b010;
            end
            default: begin          // after LNK: order ALU, LD, LNK
                if      (req_i[0]) gnt_o = 3'b001;
                else if (req_i[1]) gnt_o = 3'b010;
                else if (req_i[2]) gnt_o = 3'b100;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/reg_write_sched.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_sched
// Purpose  : Schedules register-bank write-backs from three requesters
//            (ALU -> rd, load -> rt, link -> ra). Each requester owns a
//            1-deep pending slot; a round-robin arbiter picks a slot, which
//            is presented for one settle cycle (SELECT) and then written
//            (WRITE). Writes to register 0 from ALU/LD are suppressed.
// Ports    : clk, reset (async, active-high)
//            alu_req/idx/data -> alu_ack   ALU result request
//            ld_req/idx/data  -> ld_ack    load result request
//            lnk_req/data     -> lnk_ack   link (return address) request
//            wr_sel, wr_data, reg_write    register-bank write port
//            busy                          not idle or any slot pending
// Revision : 1.0 - initial release
// ============================================================================
module reg_write_sched
    import reg_write_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_req,
    input  logic [4:0]        alu_idx,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ack,
    input  logic              ld_req,
    input  logic [4:0]        ld_idx,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ack,
    input  logic              lnk_req,
    input  logic [DATA_W-1:0] lnk_data,
    output logic              lnk_ack,
    output logic [1:0]        wr_sel,
    output logic [DATA_W-1:0] wr_data,
    output logic              reg_write,
    output logic              busy
);

    state_t            state_q;
    logic [1:0]        grant_q;
    logic [1:0]        last_grant_q;
    logic [2:0]        valid_q, valid_d;
    logic [DATA_W-1:0] data_q [N_SRC];
    logic [DATA_W-1:0] data_d [N_SRC];
    logic [4:0]        idx_q  [N_SRC];
    logic [4:0]        idx_d  [N_SRC];
    logic [1:0]        wr_sel_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              reg_write_q;

    logic [2:0]        req_vec, ack_vec, clear_vec, arb_req, arb_gnt;
    logic [1:0]        gnt_src;
    logic [DATA_W-1:0] in_data [N_SRC];
    logic [4:0]        in_idx  [N_SRC];

    assign req_vec = {lnk_req, ld_req, alu_req};

    always_comb begin
        in_data[SRC_ALU] = alu_data;
        in_data[SRC_LD]  = ld_data;
        in_data[SRC_LNK] = lnk_data;
        in_idx[SRC_ALU]  = alu_idx;
        in_idx[SRC_LD]   = ld_idx;
        in_idx[SRC_LNK]  = RA_IDX;
    end

    // The granted slot empties at the end of WRITE, so it may accept a new
    // request in that same cycle.
    always_comb begin
        clear_vec = 3'b000;
        if (state_q == ST_WRITE) begin
            case (grant_q)
                SRC_ALU: clear_vec = 3'b001;
                SRC_LD:  clear_vec = 3'b010;
                default: clear_vec = 3'b100;
            endcase
        end
    end

    assign ack_vec = req_vec & (~valid_q | clear_vec);
    // A slot being cleared and reloaded in one cycle ends up holding the new
    // request, so nothing is lost or written twice.
    assign valid_d = (valid_q & ~clear_vec) | ack_vec;

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            data_d[i] = ack_vec[i] ? in_data[i] : data_q[i];
            idx_d[i]  = ack_vec[i] ? in_idx[i]  : idx_q[i];
        end
    end

    // From IDLE only slots already pending are eligible; at the end of WRITE
    // the post-edge view is used so a slot reloaded this cycle can follow
    // straight on, giving one write every two cycles.
    assign arb_req = (state_q == ST_WRITE) ? valid_d : valid_q;

    rr_arbiter3 u_arb (
        .req_i  (arb_req),
        .last_i (last_grant_q),
        .gnt_o  (arb_gnt)
    );

    assign gnt_src = onehot_to_src(arb_gnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= SRC_ALU;
            last_grant_q <= SRC_LNK;    // ALU wins the first arbitration
            valid_q      <= 3'b000;
            wr_sel_q     <= SEL_ALT;
            wr_data_q    <= '0;
            reg_write_q  <= 1'b0;
            for (int i = 0; i < N_SRC; i++) begin
                data_q[i] <= '0;
                idx_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < N_SRC; i++) begin
                data_q[i] <= data_d[i];
                idx_q[i]  <= idx_d[i];
            end

            case (state_q)
                ST_IDLE: begin
                    reg_write_q <= 1'b0;
                    if (|valid_q) begin
                        state_q      <= ST_SELECT;
                        grant_q      <= gnt_src;
                        last_grant_q <= gnt_src;
                        wr_sel_q     <= src_to_sel(gnt_src);
                        wr_data_q    <= data_q[gnt_src];
                    end
                end
                ST_SELECT: begin
                    state_q     <= ST_WRITE;
                    // Register 0 is hard-wired; link writes always go to ra.
                    reg_write_q <= (grant_q == SRC_LNK) || (idx_q[grant_q] != 5'd0);
                end
                ST_WRITE: begin
                    reg_write_q <= 1'b0;
                    if (|valid_d) begin
                        state_q      <= ST_SELECT;
                        grant_q      <= gnt_src;
                        last_grant_q <= gnt_src;
                        wr_sel_q     <= src_to_sel(gnt_src);
                        wr_data_q    <= data_d[gnt_src];
                    end else begin
                        state_q   <= ST_IDLE;
                        wr_sel_q  <= SEL_ALT;
                        wr_data_q <= '0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    reg_write_q <= 1'b0;
                    wr_sel_q    <= SEL_ALT;
                    wr_data_q   <= '0;
                end
            endcase
        end
    end

    assign alu_ack   = ack_vec[0];
    assign ld_ack    = ack_vec[1];
    assign lnk_ack   = ack_vec[2];
    assign wr_sel    = wr_sel_q;
    assign wr_data   = wr_data_q;
    assign reg_write = reg_write_q;
    assign busy      = (state_q != ST_IDLE) || (|valid_q);

endmodule
`default_nettype wire
